// File: rtl/pq_cmd_initiator.sv
// Command-side initiator for one hwpq priority queue (max-first).
// Latency: refused ops and PEEK respond the cycle after accept; issued ops
//   respond W+1 cycles after accept (W = per-op settle time).
// Backpressure: o_op_ready only in IDLE; response held until i_rsp_ready.
//
// Ports:
//   i_CLK, i_RST                 clock, async active-high reset
//   i_op_*/o_op_ready            request channel (code, key)
//   o_rsp_*/i_rsp_ready          response channel (top value, status)
//   o_pq_wrt/o_pq_read/o_pq_data registered strobes and key to the queue
//   i_pq_full/i_pq_empty/i_pq_data queue flags and current top value
//   o_drop_cnt                   saturating count of refused requests
module pq_cmd_initiator #(
  parameter int DATA_WIDTH = 16,
  parameter int ENQ_ENA    = 1,
  parameter int ENQ_WAIT   = 128,
  parameter int DEQ_WAIT   = 1,
  parameter int REP_WAIT   = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_op_valid,
  output logic                  o_op_ready,
  input  logic [1:0]            i_op_code,
  input  logic [DATA_WIDTH-1:0] i_op_data,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic [1:0]            o_rsp_status,
  output logic                  o_pq_wrt,
  output logic                  o_pq_read,
  output logic [DATA_WIDTH-1:0] o_pq_data,
  input  logic                  i_pq_full,
  input  logic                  i_pq_empty,
  input  logic [DATA_WIDTH-1:0] i_pq_data,
  output logic [CNT_WIDTH-1:0]  o_drop_cnt
);

  localparam logic [1:0] OP_ENQ  = 2'b00;
  localparam logic [1:0] OP_DEQ  = 2'b01;
  localparam logic [1:0] OP_REP  = 2'b10;
  localparam logic [1:0] OP_PEEK = 2'b11;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_FULL     = 2'b01;
  localparam logic [1:0] ST_EMPTY    = 2'b10;
  localparam logic [1:0] ST_DISABLED = 2'b11;

  // Counter only ever holds W-1, so it is sized for the largest settle time.
  localparam int MAX_WAIT_A = (ENQ_WAIT > DEQ_WAIT) ? ENQ_WAIT : DEQ_WAIT;
  localparam int MAX_WAIT   = (MAX_WAIT_A > REP_WAIT) ? MAX_WAIT_A : REP_WAIT;
  localparam int CW         = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  localparam logic [CW-1:0] ENQ_M1 = CW'(ENQ_WAIT - 1);
  localparam logic [CW-1:0] DEQ_M1 = CW'(DEQ_WAIT - 1);
  localparam logic [CW-1:0] REP_M1 = CW'(REP_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                  state;
  logic [CW-1:0]           wait_cnt;
  logic [CW-1:0]           wait_m1_q;
  logic [DATA_WIDTH-1:0]   pend_data;
  logic [1:0]              pend_status;

  // Decision made on the sampled request and queue flags at the accept edge.
  logic                  dec_wrt;
  logic                  dec_read;
  logic [1:0]            dec_status;
  logic [DATA_WIDTH-1:0] dec_data;
  logic [CW-1:0]         dec_wait_m1;
  logic [DATA_WIDTH-1:0] top_or_zero;

  assign top_or_zero = i_pq_empty ? '0 : i_pq_data;

  always_comb begin
    dec_wrt     = 1'b0;
    dec_read    = 1'b0;
    dec_status  = ST_OK;
    dec_data    = '0;
    dec_wait_m1 = '0;
    case (i_op_code)
      OP_ENQ: begin
        if (ENQ_ENA == 0) begin
          dec_status = ST_DISABLED;
        end else if (i_pq_full) begin
          dec_status = ST_FULL;
        end else begin
          dec_wrt     = 1'b1;
          dec_wait_m1 = ENQ_M1;
        end
      end
      OP_DEQ: begin
        if (i_pq_empty) begin
          dec_status = ST_EMPTY;
        end else begin
          dec_read    = 1'b1;
          dec_data    = i_pq_data;
          dec_wait_m1 = DEQ_M1;
        end
      end
      OP_REP: begin
        // REPLACE is a pop+push in one strobe cycle, legal even when the
        // queue is full or empty, and unaffected by ENQ_ENA.
        dec_wrt     = 1'b1;
        dec_read    = 1'b1;
        dec_data    = top_or_zero;
        dec_wait_m1 = REP_M1;
      end
      OP_PEEK: begin
        dec_data = top_or_zero;
      end
      default: begin
        dec_status = ST_OK;
      end
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      wait_m1_q    <= '0;
      pend_data    <= '0;
      pend_status  <= ST_OK;
      o_op_ready   <= 1'b1;
      o_rsp_valid  <= 1'b0;
      o_rsp_data   <= '0;
      o_rsp_status <= ST_OK;
      o_pq_wrt     <= 1'b0;
      o_pq_read    <= 1'b0;
      o_pq_data    <= '0;
      o_drop_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_op_valid) begin
            o_op_ready <= 1'b0;
            if (dec_status != ST_OK && o_drop_cnt != '1) begin
              o_drop_cnt <= o_drop_cnt + CNT_WIDTH'(1);
            end
            if (dec_wrt || dec_read) begin
              state       <= S_ISSUE;
              o_pq_wrt    <= dec_wrt;
              o_pq_read   <= dec_read;
              o_pq_data   <= i_op_data;
              wait_m1_q   <= dec_wait_m1;
              pend_data   <= dec_data;
              pend_status <= dec_status;
            end else begin
              state        <= S_RESP;
              o_rsp_valid  <= 1'b1;
              o_rsp_data   <= dec_data;
              o_rsp_status <= dec_status;
            end
          end
        end
        S_ISSUE: begin
          o_pq_wrt  <= 1'b0;
          o_pq_read <= 1'b0;
          o_pq_data <= '0;
          wait_cnt  <= wait_m1_q;
          // The strobe cycle itself is the first settle cycle, so W=1 needs
          // no WAIT cycles and the response follows immediately.
          if (wait_m1_q == '0) begin
            state        <= S_RESP;
            o_rsp_valid  <= 1'b1;
            o_rsp_data   <= pend_data;
            o_rsp_status <= pend_status;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - CW'(1);
          // Leaving on count 1 keeps rsp_valid at exactly W+1 cycles after
          // accept while the counter still runs W-1 down to 0.
          if (wait_cnt == CW'(1)) begin
            state        <= S_RESP;
            o_rsp_valid  <= 1'b1;
            o_rsp_data   <= pend_data;
            o_rsp_status <= pend_status;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            state        <= S_IDLE;
            o_op_ready   <= 1'b1;
            o_rsp_valid  <= 1'b0;
            o_rsp_data   <= '0;
            o_rsp_status <= ST_OK;
          end
        end
        default: begin
          state      <= S_IDLE;
          o_op_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pq_cmd_initiator.sv
module tb_pq_cmd_initiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // DUT A: enqueue enabled, long ENQ settle, attached to a queue model.
  logic        a_op_valid, a_op_ready, a_rsp_valid, a_rsp_ready;
  logic [1:0]  a_op_code, a_rsp_status;
  logic [15:0] a_op_data, a_rsp_data, a_pq_data, a_pq_top, a_drop_cnt;
  logic        a_pq_wrt, a_pq_read, a_pq_full, a_pq_empty;

  // DUT B: enqueue disabled, 2-bit drop counter, flags driven directly.
  logic        b_op_valid, b_op_ready, b_rsp_valid, b_rsp_ready;
  logic [1:0]  b_op_code, b_rsp_status, b_drop_cnt;
  logic [15:0] b_op_data, b_rsp_data, b_pq_data, b_pq_top;
  logic        b_pq_wrt, b_pq_read, b_pq_full, b_pq_empty;

  pq_cmd_initiator #(.DATA_WIDTH(16), .ENQ_ENA(1), .ENQ_WAIT(128), .DEQ_WAIT(1),
                     .REP_WAIT(1), .CNT_WIDTH(16)) dut_a (
    .i_CLK(clk), .i_RST(rst), .i_op_valid(a_op_valid), .o_op_ready(a_op_ready),
    .i_op_code(a_op_code), .i_op_data(a_op_data), .o_rsp_valid(a_rsp_valid),
    .i_rsp_ready(a_rsp_ready), .o_rsp_data(a_rsp_data), .o_rsp_status(a_rsp_status),
    .o_pq_wrt(a_pq_wrt), .o_pq_read(a_pq_read), .o_pq_data(a_pq_data),
    .i_pq_full(a_pq_full), .i_pq_empty(a_pq_empty), .i_pq_data(a_pq_top),
    .o_drop_cnt(a_drop_cnt));

  pq_cmd_initiator #(.DATA_WIDTH(16), .ENQ_ENA(0), .ENQ_WAIT(1), .DEQ_WAIT(1),
                     .REP_WAIT(3), .CNT_WIDTH(2)) dut_b (
    .i_CLK(clk), .i_RST(rst), .i_op_valid(b_op_valid), .o_op_ready(b_op_ready),
    .i_op_code(b_op_code), .i_op_data(b_op_data), .o_rsp_valid(b_rsp_valid),
    .i_rsp_ready(b_rsp_ready), .o_rsp_data(b_rsp_data), .o_rsp_status(b_rsp_status),
    .o_pq_wrt(b_pq_wrt), .o_pq_read(b_pq_read), .o_pq_data(b_pq_data),
    .i_pq_full(b_pq_full), .i_pq_empty(b_pq_empty), .i_pq_data(b_pq_top),
    .o_drop_cnt(b_drop_cnt));

  // Four-entry max-first queue model behind DUT A.
  logic [15:0] q_mem [4];
  int          q_cnt = 0;
  assign a_pq_full  = (q_cnt == 4);
  assign a_pq_empty = (q_cnt == 0);
  always_comb begin
    a_pq_top = 16'd0;
    for (int i = 0; i < 4; i++)
      if (i < q_cnt && q_mem[i] > a_pq_top) a_pq_top = q_mem[i];
  end
  always @(posedge clk) begin : model
    int mi;
    mi = 0;
    for (int i = 1; i < 4; i++)
      if (i < q_cnt && q_mem[i] > q_mem[mi]) mi = i;
    if (a_pq_wrt && a_pq_read) begin
      if (q_cnt == 0) begin q_mem[0] <= a_pq_data; q_cnt <= 1; end
      else q_mem[mi] <= a_pq_data;
    end else if (a_pq_wrt && q_cnt < 4) begin
      q_mem[q_cnt] <= a_pq_data; q_cnt <= q_cnt + 1;
    end else if (a_pq_read && q_cnt > 0) begin
      q_mem[mi] <= q_mem[q_cnt-1]; q_cnt <= q_cnt - 1;
    end
  end

  // Selected-DUT views used by the generic op task.
  logic        sel;
  logic        c_op_ready, c_rsp_valid, c_pq_wrt, c_pq_read;
  logic [1:0]  c_rsp_status;
  logic [15:0] c_rsp_data, c_pq_data;
  always_comb begin
    c_op_ready   = sel ? b_op_ready   : a_op_ready;
    c_rsp_valid  = sel ? b_rsp_valid  : a_rsp_valid;
    c_pq_wrt     = sel ? b_pq_wrt     : a_pq_wrt;
    c_pq_read    = sel ? b_pq_read    : a_pq_read;
    c_rsp_status = sel ? b_rsp_status : a_rsp_status;
    c_rsp_data   = sel ? b_rsp_data   : a_rsp_data;
    c_pq_data    = sel ? b_pq_data    : a_pq_data;
  end

  int checks = 0;
  int failures = 0;

  int          r_lat, r_wrt, r_rd, r_both, r_baddata, r_unstable, r_rdy_bad;
  logic [15:0] r_sdata, r_data;
  logic [1:0]  r_stat;
  logic        r_rdy_after, r_valid_after;

  task automatic drive_req(input logic v, input logic [1:0] code, input logic [15:0] data);
    if (sel) begin b_op_valid = v; b_op_code = code; b_op_data = data; end
    else     begin a_op_valid = v; a_op_code = code; a_op_data = data; end
  endtask

  task automatic drive_rsp_ready(input logic r);
    if (sel) b_rsp_ready = r; else a_rsp_ready = r;
  endtask

  // One request on the selected DUT; records latency, strobes and response.
  task automatic do_op(input logic [1:0] code, input logic [15:0] data, input int hold);
    r_lat = -1; r_wrt = 0; r_rd = 0; r_both = 0; r_baddata = 0;
    r_unstable = 0; r_rdy_bad = 0; r_sdata = 16'd0;
    @(negedge clk);
    drive_req(1'b1, code, data);
    for (int i = 0; i < 10 && !c_op_ready; i++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    drive_req(1'b0, 2'b00, 16'hdead);
    for (int k = 1; k <= 300; k++) begin
      if (c_pq_wrt) r_wrt++;
      if (c_pq_read) r_rd++;
      if (c_pq_wrt && c_pq_read) r_both++;
      if (c_pq_wrt || c_pq_read) r_sdata = c_pq_data;
      else if (c_pq_data !== 16'd0) r_baddata++;
      if (c_op_ready !== 1'b0) r_rdy_bad++;
      if (c_rsp_valid === 1'b1) begin r_lat = k; break; end
      @(negedge clk);
    end
    r_data = c_rsp_data;
    r_stat = c_rsp_status;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (c_rsp_valid !== 1'b1 || c_rsp_data !== r_data || c_rsp_status !== r_stat ||
          c_op_ready !== 1'b0) r_unstable++;
    end
    drive_rsp_ready(1'b1);
    @(posedge clk);
    @(negedge clk);
    drive_rsp_ready(1'b0);
    r_rdy_after = c_op_ready;
    r_valid_after = c_rsp_valid;
  endtask

  task automatic test_reset;
    rst = 1'b1; sel = 1'b0;
    a_op_valid = 0; a_op_code = 0; a_op_data = 0; a_rsp_ready = 0;
    b_op_valid = 0; b_op_code = 0; b_op_data = 0; b_rsp_ready = 0;
    b_pq_full = 0; b_pq_empty = 1; b_pq_top = 0;
    repeat (2) @(negedge clk);
    checks++; if (a_op_ready !== 1'b1) begin failures++; $display("FAIL reset_op_ready got=%b exp=1", a_op_ready); end
    checks++; if ({a_rsp_valid, a_rsp_data, a_rsp_status, a_pq_wrt, a_pq_read, a_pq_data, a_drop_cnt} !== '0) begin
      failures++; $display("FAIL reset_outputs got rsp_v=%b d=%0d s=%0d w=%b r=%b pd=%0d drop=%0d exp all 0",
        a_rsp_valid, a_rsp_data, a_rsp_status, a_pq_wrt, a_pq_read, a_pq_data, a_drop_cnt); end
    checks++; if (b_op_ready !== 1'b1 || b_drop_cnt !== 2'd0) begin failures++; $display("FAIL reset_b got rdy=%b drop=%0d exp 1/0", b_op_ready, b_drop_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_enq;
    sel = 1'b0;
    do_op(2'b00, 16'd37, 0);
    checks++; if (r_lat !== 129) begin failures++; $display("FAIL enq37_latency got=%0d exp=129", r_lat); end
    checks++; if (r_wrt !== 1 || r_rd !== 0 || r_sdata !== 16'd37) begin failures++; $display("FAIL enq37_strobe got wrt=%0d rd=%0d data=%0d exp 1/0/37", r_wrt, r_rd, r_sdata); end
    checks++; if (r_stat !== 2'b00 || r_data !== 16'd0) begin failures++; $display("FAIL enq37_rsp got st=%0d d=%0d exp 0/0", r_stat, r_data); end
    checks++; if (r_baddata !== 0 || r_rdy_bad !== 0) begin failures++; $display("FAIL enq37_idle_outputs got baddata=%0d rdy_bad=%0d exp 0/0", r_baddata, r_rdy_bad); end
    checks++; if (r_rdy_after !== 1'b1 || r_valid_after !== 1'b0) begin failures++; $display("FAIL enq37_return got rdy=%b v=%b exp 1/0", r_rdy_after, r_valid_after); end
    do_op(2'b11, 16'd0, 0);
    checks++; if (r_lat !== 1 || r_data !== 16'd37 || r_stat !== 2'b00 || r_wrt + r_rd !== 0) begin
      failures++; $display("FAIL peek37 got lat=%0d d=%0d st=%0d strobes=%0d exp 1/37/0/0", r_lat, r_data, r_stat, r_wrt + r_rd); end
  endtask

  task automatic test_back_to_back;
    int acc, rsp, bad;
    acc = 0; rsp = 0; bad = 0;
    @(negedge clk);
    a_rsp_ready = 1'b1; a_op_valid = 1'b1; a_op_code = 2'b11;
    for (int i = 0; i < 8; i++) begin
      if (a_op_ready) acc++;
      if (a_rsp_valid) begin rsp++; if (a_rsp_data !== 16'd37) bad++; end
      @(negedge clk);
    end
    a_op_valid = 1'b0; a_rsp_ready = 1'b0;
    checks++; if (acc !== 4 || rsp !== 4 || bad !== 0) begin failures++; $display("FAIL peek_b2b got acc=%0d rsp=%0d bad=%0d exp 4/4/0", acc, rsp, bad); end
  endtask

  task automatic test_full;
    logic [15:0] vals [3];
    vals[0] = 16'd10; vals[1] = 16'd20; vals[2] = 16'd30;
    for (int i = 0; i < 3; i++) begin
      do_op(2'b00, vals[i], 0);
      checks++; if (r_lat !== 129 || r_stat !== 2'b00 || r_wrt !== 1) begin failures++; $display("FAIL fill_%0d got lat=%0d st=%0d wrt=%0d exp 129/0/1", i, r_lat, r_stat, r_wrt); end
    end
    checks++; if (a_drop_cnt !== 16'd0) begin failures++; $display("FAIL drop_before_full got=%0d exp=0", a_drop_cnt); end
    do_op(2'b00, 16'd5, 0);
    checks++; if (r_lat !== 1 || r_stat !== 2'b01 || r_data !== 16'd0 || r_wrt + r_rd !== 0) begin
      failures++; $display("FAIL enq_full got lat=%0d st=%0d d=%0d strobes=%0d exp 1/1/0/0", r_lat, r_stat, r_data, r_wrt + r_rd); end
    checks++; if (a_drop_cnt !== 16'd1) begin failures++; $display("FAIL drop_after_full got=%0d exp=1", a_drop_cnt); end
  endtask

  task automatic test_deq;
    logic [15:0] exp [4];
    exp[0] = 16'd37; exp[1] = 16'd30; exp[2] = 16'd20; exp[3] = 16'd10;
    for (int i = 0; i < 4; i++) begin
      do_op(2'b01, 16'd0, 0);
      checks++; if (r_data !== exp[i] || r_stat !== 2'b00) begin failures++; $display("FAIL drain_%0d got d=%0d st=%0d exp %0d/0", i, r_data, r_stat, exp[i]); end
    end
    do_op(2'b00, 16'd900, 0);
    do_op(2'b00, 16'd12, 0);
    do_op(2'b01, 16'd0, 0);
    checks++; if (r_lat !== 2 || r_data !== 16'd900 || r_stat !== 2'b00) begin failures++; $display("FAIL deq900 got lat=%0d d=%0d st=%0d exp 2/900/0", r_lat, r_data, r_stat); end
    checks++; if (r_rd !== 1 || r_wrt !== 0) begin failures++; $display("FAIL deq900_strobe got rd=%0d wrt=%0d exp 1/0", r_rd, r_wrt); end
    do_op(2'b01, 16'd0, 0);
    checks++; if (r_data !== 16'd12 || r_stat !== 2'b00) begin failures++; $display("FAIL deq12 got d=%0d st=%0d exp 12/0", r_data, r_stat); end
    do_op(2'b01, 16'd0, 0);
    checks++; if (r_lat !== 1 || r_stat !== 2'b10 || r_data !== 16'd0 || r_wrt + r_rd !== 0) begin
      failures++; $display("FAIL deq_empty got lat=%0d st=%0d d=%0d strobes=%0d exp 1/2/0/0", r_lat, r_stat, r_data, r_wrt + r_rd); end
    checks++; if (a_drop_cnt !== 16'd2) begin failures++; $display("FAIL drop_after_empty got=%0d exp=2", a_drop_cnt); end
  endtask

  task automatic test_replace;
    do_op(2'b10, 16'd50, 0);
    checks++; if (r_stat !== 2'b00 || r_data !== 16'd0 || r_lat !== 2 || r_both !== 1 || r_sdata !== 16'd50) begin
      failures++; $display("FAIL rep_empty got st=%0d d=%0d lat=%0d both=%0d key=%0d exp 0/0/2/1/50", r_stat, r_data, r_lat, r_both, r_sdata); end
    do_op(2'b10, 16'd70, 0);
    checks++; if (r_data !== 16'd50 || r_both !== 1 || r_wrt !== 1 || r_rd !== 1 || r_sdata !== 16'd70) begin
      failures++; $display("FAIL rep70 got d=%0d both=%0d wrt=%0d rd=%0d key=%0d exp 50/1/1/1/70", r_data, r_both, r_wrt, r_rd, r_sdata); end
    do_op(2'b11, 16'd0, 0);
    checks++; if (r_data !== 16'd70) begin failures++; $display("FAIL peek70 got=%0d exp=70", r_data); end
  endtask

  task automatic test_disabled;
    sel = 1'b1;
    b_pq_full = 1'b0; b_pq_empty = 1'b1; b_pq_top = 16'd0;
    do_op(2'b00, 16'd8, 10);
    checks++; if (r_stat !== 2'b11 || r_lat !== 1 || r_wrt + r_rd !== 0 || r_data !== 16'd0) begin
      failures++; $display("FAIL enq_disabled got st=%0d lat=%0d strobes=%0d d=%0d exp 3/1/0/0", r_stat, r_lat, r_wrt + r_rd, r_data); end
    checks++; if (r_unstable !== 0) begin failures++; $display("FAIL rsp_hold_stable got unstable=%0d exp=0", r_unstable); end
    checks++; if (b_drop_cnt !== 2'd1) begin failures++; $display("FAIL b_drop1 got=%0d exp=1", b_drop_cnt); end
    b_pq_empty = 1'b0; b_pq_top = 16'd600;
    do_op(2'b10, 16'd44, 0);
    checks++; if (r_lat !== 4 || r_both !== 1 || r_sdata !== 16'd44 || r_data !== 16'd600 || r_stat !== 2'b00) begin
      failures++; $display("FAIL b_replace got lat=%0d both=%0d key=%0d d=%0d st=%0d exp 4/1/44/600/0", r_lat, r_both, r_sdata, r_data, r_stat); end
    do_op(2'b00, 16'd1, 0);
    b_pq_empty = 1'b1;
    do_op(2'b01, 16'd0, 0);
    checks++; if (b_drop_cnt !== 2'd3) begin failures++; $display("FAIL b_drop3 got=%0d exp=3", b_drop_cnt); end
    do_op(2'b00, 16'd2, 0);
    checks++; if (b_drop_cnt !== 2'd3) begin failures++; $display("FAIL b_drop_saturate got=%0d exp=3", b_drop_cnt); end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid;
    sel = 1'b0;
    @(negedge clk);
    a_op_valid = 1'b1; a_op_code = 2'b00; a_op_data = 16'd99;
    @(posedge clk);
    @(negedge clk);
    a_op_valid = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (a_op_ready !== 1'b0 || a_rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_wait got rdy=%b v=%b exp 0/0", a_op_ready, a_rsp_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (a_op_ready !== 1'b1 || a_pq_wrt !== 1'b0 || a_pq_read !== 1'b0 || a_rsp_valid !== 1'b0 || a_drop_cnt !== 16'd0) begin
      failures++; $display("FAIL mid_reset got rdy=%b w=%b r=%b v=%b drop=%0d exp 1/0/0/0/0", a_op_ready, a_pq_wrt, a_pq_read, a_rsp_valid, a_drop_cnt); end
    @(negedge clk);
    rst = 1'b0;
    do_op(2'b11, 16'd0, 0);
    checks++; if (r_lat !== 1 || r_data !== 16'd99 || r_stat !== 2'b00) begin failures++; $display("FAIL after_reset_peek got lat=%0d d=%0d st=%0d exp 1/99/0", r_lat, r_data, r_stat); end
  endtask

  initial begin
    test_reset();
    test_enq();
    test_back_to_back();
    test_full();
    test_deq();
    test_replace();
    test_disabled();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
